collision_flag_bank: RTL and testbench

COLLISION_FLAG_BANK -- requirements
Module: collision_flag_bank

---
 rtl/collision_pkg.sv | 32 +++
 rtl/collision_flag_bank_if.sv | 41 ++++
 rtl/sprite_overlap_cmp.sv | 44 ++++
 rtl/collision_flag_bank.sv | 174 +++++++++++++++++
 tb/tb_collision_flag_bank.sv | 224 ++++++++++++++++++++++
 5 files changed

// File: rtl/collision_pkg.sv
// Shared definitions for the sprite collision path: sprite word layout,
// sprite edge size and the flag bank FSM encoding.
package collision_pkg;

  // Sprite word layout
  localparam int ACTIVE_BIT  = 29;
  localparam int X_MSB       = 28;
  localparam int X_LSB       = 19;
  localparam int Y_MSB       = 18;
  localparam int Y_LSB       = 9;
  localparam int COORD_W     = 10;

  // Sprite edge length in pixels
  localparam int SPRITE_SIZE = 20;

  // Flag bank frame FSM
  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ACCUM   = 3'd1,
    DRAIN   = 3'd2,
    PUBLISH = 3'd3,
    HOLD    = 3'd4
  } state_t;

  // Unsigned distance between two coordinates; the smaller operand is
  // always subtracted so the result never wraps.
  function automatic logic [COORD_W-1:0] abs_diff(input logic [COORD_W-1:0] a,
                                                  input logic [COORD_W-1:0] b);
    return (a >= b) ? (a - b) : (b - a);
  endfunction

endpackage

// File: rtl/collision_flag_bank_if.sv
// Signal bundle between the collision controller / flag consumer and the
// collision flag bank.
//
// Handshake: flags_valid rises for a frame once it has been published and
// stays high until the consumer drives flags_read=1 on a clock edge while
// flags_valid=1; that edge completes the transfer and drops flags_valid.
// collision_flags/collision_count are stable whenever flags_valid is high.
interface collision_flag_bank_if
  import collision_pkg::*;
#(
  parameter int N_SPRITE = 32,
  parameter int SEL_W    = 5,
  parameter int DATA_W   = 32
);

  logic                clear_n;
  logic                update_en;
  logic [SEL_W-1:0]    mobile_idx;
  logic [SEL_W-1:0]    comparison_idx;
  logic [DATA_W-1:0]   m_sprite;
  logic [DATA_W-1:0]   c_sprite;
  logic                analysis_done_n;
  logic                flags_read;
  logic [N_SPRITE-1:0] collision_flags;
  logic                flags_valid;
  logic [SEL_W:0]      collision_count;
  state_t              state_dbg;

  modport master (
    output clear_n, update_en, mobile_idx, comparison_idx,
           m_sprite, c_sprite, analysis_done_n, flags_read,
    input  collision_flags, flags_valid, collision_count, state_dbg
  );

  modport slave (
    input  clear_n, update_en, mobile_idx, comparison_idx,
           m_sprite, c_sprite, analysis_done_n, flags_read,
    output collision_flags, flags_valid, collision_count, state_dbg
  );

endinterface

// File: rtl/sprite_overlap_cmp.sv
// Combinational sprite geometry: per-axis distances and activity of the
// incoming pair, and the overlap decision on a previously latched pair.
module sprite_overlap_cmp
  import collision_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int SEL_W   = 5,
  parameter int SIZE_PX = 20
)(
  input  logic [DATA_W-1:0]  m_sprite,
  input  logic [DATA_W-1:0]  c_sprite,
  output logic [COORD_W-1:0] dx,
  output logic [COORD_W-1:0] dy,
  output logic               both_active,
  input  logic [COORD_W-1:0] s_dx,
  input  logic [COORD_W-1:0] s_dy,
  input  logic               s_act,
  input  logic [SEL_W-1:0]   s_mi,
  input  logic [SEL_W-1:0]   s_ci,
  output logic               overlap
);

  localparam logic [COORD_W-1:0] SIZE_L = COORD_W'(SIZE_PX);

  logic [COORD_W-1:0] mx, my, cx, cy;
  logic               sprite_unused;

  assign mx = m_sprite[X_MSB:X_LSB];
  assign my = m_sprite[Y_MSB:Y_LSB];
  assign cx = c_sprite[X_MSB:X_LSB];
  assign cy = c_sprite[Y_MSB:Y_LSB];

  assign dx          = abs_diff(mx, cx);
  assign dy          = abs_diff(my, cy);
  assign both_active = m_sprite[ACTIVE_BIT] & c_sprite[ACTIVE_BIT];

  // A sprite never collides with itself.
  assign overlap = s_act && (s_dx < SIZE_L) && (s_dy < SIZE_L) && (s_mi != s_ci);

  // Upper bits and the offset field carry nothing for the geometry test.
  assign sprite_unused = ^{m_sprite[DATA_W-1:ACTIVE_BIT+1], m_sprite[Y_LSB-1:0],
                           c_sprite[DATA_W-1:ACTIVE_BIT+1], c_sprite[Y_LSB-1:0]};

endmodule

// File: rtl/collision_flag_bank.sv
// Per-frame collision flag accumulator. Pair evaluations requested by the
// controller are pipelined in two stages into a pending flag vector; at the
// end of the frame the pending flags are published and held for the consumer.
module collision_flag_bank
  import collision_pkg::*;
#(
  parameter int N_SPRITE    = 32,
  parameter int SEL_W       = 5,
  parameter int DATA_W      = 32,
  parameter int SPRITE_SIZE = collision_pkg::SPRITE_SIZE
)(
  input logic                  clk,
  input logic                  reset,
  collision_flag_bank_if.slave bus
);

  localparam int CNT_W = SEL_W + 1;

  state_t              state_q, state_d;
  logic                drain_q, drain_d;
  logic                upd_q, done_q;
  logic                upd_rise, done_fall, accepting, load_s1, commit;

  logic                s1_valid_q;
  logic [COORD_W-1:0]  s1_dx_q, s1_dy_q;
  logic                s1_act_q;
  logic [SEL_W-1:0]    s1_mi_q, s1_ci_q;

  logic [COORD_W-1:0]  dx_w, dy_w;
  logic                act_w, overlap_w;

  logic [N_SPRITE-1:0] pending_q, pending_d;
  logic [CNT_W-1:0]    count_q, count_d;

  logic [N_SPRITE-1:0] flags_q;
  logic [CNT_W-1:0]    pub_count_q;
  logic                valid_q;

  // Edges are taken against last cycle's copies, so a held strobe only
  // produces one request.
  assign upd_rise  = bus.update_en & ~upd_q;
  assign done_fall = ~bus.analysis_done_n & done_q;

  // DRAIN still accepts requests so late pairs are not lost; a coinciding
  // frame clear discards the request.
  assign accepting = (state_q == ACCUM) || (state_q == DRAIN);
  assign load_s1   = upd_rise & accepting & bus.clear_n;
  assign commit    = s1_valid_q & overlap_w;

  sprite_overlap_cmp #(
    .DATA_W  (DATA_W),
    .SEL_W   (SEL_W),
    .SIZE_PX (SPRITE_SIZE)
  ) u_cmp (
    .m_sprite    (bus.m_sprite),
    .c_sprite    (bus.c_sprite),
    .dx          (dx_w),
    .dy          (dy_w),
    .both_active (act_w),
    .s_dx        (s1_dx_q),
    .s_dy        (s1_dy_q),
    .s_act       (s1_act_q),
    .s_mi        (s1_mi_q),
    .s_ci        (s1_ci_q),
    .overlap     (overlap_w)
  );

  // Edge-detect registers for the controller strobes.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      upd_q  <= 1'b0;
      done_q <= 1'b1;
    end else begin
      upd_q  <= bus.update_en;
      done_q <= bus.analysis_done_n;
    end
  end

  // Stage 1: capture distances, activity and indices of a requested pair.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s1_valid_q <= 1'b0;
      s1_dx_q    <= '0;
      s1_dy_q    <= '0;
      s1_act_q   <= 1'b0;
      s1_mi_q    <= '0;
      s1_ci_q    <= '0;
    end else begin
      s1_valid_q <= load_s1;
      if (load_s1) begin
        s1_dx_q  <= dx_w;
        s1_dy_q  <= dy_w;
        s1_act_q <= act_w;
        s1_mi_q  <= bus.mobile_idx;
        s1_ci_q  <= bus.comparison_idx;
      end
    end
  end

  // Stage 2: fold an overlapping pair into the pending flags; clear wins.
  always_comb begin
    pending_d = pending_q;
    count_d   = count_q;
    if (commit) begin
      pending_d[s1_mi_q] = 1'b1;
      pending_d[s1_ci_q] = 1'b1;
      if (count_q != '1) count_d = count_q + CNT_W'(1);
    end
    if (!bus.clear_n) begin
      pending_d = '0;
      count_d   = '0;
    end
  end

  // Pending accumulator registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pending_q <= '0;
      count_q   <= '0;
    end else begin
      pending_q <= pending_d;
      count_q   <= count_d;
    end
  end

  // Frame FSM next-state: drain runs two cycles so in-flight pairs land.
  always_comb begin
    state_d = state_q;
    drain_d = 1'b0;
    unique case (state_q)
      IDLE:    if (!bus.clear_n) state_d = ACCUM;
      ACCUM:   if (done_fall) state_d = DRAIN;
      DRAIN: begin
        drain_d = 1'b1;
        if (drain_q) state_d = PUBLISH;
      end
      PUBLISH: state_d = HOLD;
      HOLD:    if (bus.flags_read) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Frame FSM state register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      drain_q <= 1'b0;
    end else begin
      state_q <= state_d;
      drain_q <= drain_d;
    end
  end

  // Published frame: includes a pair committing in the publish cycle itself.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      flags_q     <= '0;
      pub_count_q <= '0;
      valid_q     <= 1'b0;
    end else if (state_q == PUBLISH) begin
      flags_q     <= pending_d;
      pub_count_q <= count_d;
      valid_q     <= 1'b1;
    end else if (state_q == HOLD && bus.flags_read) begin
      valid_q     <= 1'b0;
    end
  end

  assign bus.collision_flags = flags_q;
  assign bus.collision_count = pub_count_q;
  assign bus.flags_valid     = valid_q;
  assign bus.state_dbg       = state_q;

endmodule

// File: tb/tb_collision_flag_bank.sv
// Directed bench for collision_flag_bank: stimulus tasks push the expected
// published frame, a negedge monitor pops and compares on each publish.
module tb_collision_flag_bank;
  import collision_pkg::*;

  localparam int N  = 32;
  localparam int SW = 5;
  localparam int DW = 32;
  localparam int EW = N + SW + 1;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  collision_flag_bank_if #(.N_SPRITE(N), .SEL_W(SW), .DATA_W(DW)) bus ();

  collision_flag_bank #(
    .N_SPRITE (N),
    .SEL_W    (SW),
    .DATA_W   (DW)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  logic [EW-1:0] exp_q[$];
  logic [EW-1:0] mon_exp;
  logic          valid_prev = 1'b0;
  int            n_cmp = 0;
  int            n_fail = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] mk(input logic act, input int x, input int y);
    logic [31:0] w;
    w = '0;
    w[ACTIVE_BIT]  = act;
    w[X_MSB:X_LSB] = x[9:0];
    w[Y_MSB:Y_LSB] = y[9:0];
    return w;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_exp(input logic [N-1:0] flags, input int count);
    logic [SW:0] c;
    c = count[SW:0];
    exp_q.push_back({c, flags});
  endtask

  task automatic do_clear();
    bus.clear_n = 1'b0;
    tick();
    bus.clear_n = 1'b1;
  endtask

  // One pair request: strobe held for 'hold' cycles, then one low cycle.
  task automatic eval(input int mi, input int ci, input logic [31:0] m,
                      input logic [31:0] c, input int hold);
    bus.mobile_idx     = mi[SW-1:0];
    bus.comparison_idx = ci[SW-1:0];
    bus.m_sprite       = m;
    bus.c_sprite       = c;
    bus.update_en      = 1'b1;
    repeat (hold) tick();
    bus.update_en      = 1'b0;
    tick();
  endtask

  // Ends the frame, waits for publish, optionally clears in HOLD, then acks.
  task automatic end_frame(input logic clear_in_hold, input logic [N-1:0] exp_flags);
    logic got;
    bus.analysis_done_n = 1'b0;
    tick();
    bus.analysis_done_n = 1'b1;
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      tick();
      got = bus.flags_valid;
    end
    check("publish_seen", got, 1);
    if (clear_in_hold) begin
      bus.clear_n = 1'b0;
      tick();
      bus.clear_n = 1'b1;
      check("hold_valid_after_clear", bus.flags_valid, 1);
      check("hold_flags_after_clear", bus.collision_flags, exp_flags);
      check("hold_state_after_clear", bus.state_dbg, HOLD);
    end
    bus.flags_read = 1'b1;
    tick();
    bus.flags_read = 1'b0;
    check("valid_cleared_on_read", bus.flags_valid, 0);
    check("idle_after_read", bus.state_dbg, IDLE);
    check("flags_kept_after_read", bus.collision_flags, exp_flags);
    tick();
  endtask

  // Monitor: compare each newly published frame against the scoreboard.
  always @(negedge clk) begin
    if (bus.flags_valid && !valid_prev) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_fail++;
        $display("FAIL unexpected_publish: got flags 0x%0h count %0d, expected no publish",
                 bus.collision_flags, bus.collision_count);
      end else begin
        mon_exp = exp_q.pop_front();
        check("pub_flags", bus.collision_flags, mon_exp[N-1:0]);
        check("pub_count", bus.collision_count, mon_exp[EW-1:N]);
      end
    end
    valid_prev = bus.flags_valid;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no end of test, expected finish before 200000");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.clear_n         = 1'b1;
    bus.update_en       = 1'b0;
    bus.mobile_idx      = '0;
    bus.comparison_idx  = '0;
    bus.m_sprite        = '0;
    bus.c_sprite        = '0;
    bus.analysis_done_n = 1'b1;
    bus.flags_read      = 1'b0;
    reset = 1'b1;
    #3 reset = 1'b0;
    repeat (3) tick();
    check("rst_flags", bus.collision_flags, 0);
    check("rst_count", bus.collision_count, 0);
    check("rst_valid", bus.flags_valid, 0);
    check("rst_state", bus.state_dbg, IDLE);
    reset = 1'b1;
    tick();

    // Basic overlap: idx 2/5, dx=10, dy=10.
    do_clear();
    eval(2, 5, mk(1, 100, 50), mk(1, 110, 60), 1);
    push_exp(32'h0000_0024, 1);
    end_frame(1'b0, 32'h0000_0024);

    // Boundary: dx=20 misses; dx=19/dy=19 (both subtraction directions) hits.
    do_clear();
    eval(0, 1, mk(1, 200, 100), mk(1, 220, 100), 1);
    eval(3, 4, mk(1, 300, 300), mk(1, 281, 319), 1);
    push_exp(32'h0000_0018, 1);
    end_frame(1'b0, 32'h0000_0018);

    // Edge in IDLE ignored; inactive sprite and self-pair never flag.
    eval(14, 15, mk(1, 50, 50), mk(1, 52, 52), 1);
    do_clear();
    eval(6, 7, mk(1, 50, 50), mk(0, 50, 50), 1);
    eval(8, 8, mk(1, 50, 50), mk(1, 50, 50), 1);
    push_exp(32'h0000_0000, 0);
    end_frame(1'b0, 32'h0000_0000);

    // Strobe held for five cycles counts once.
    do_clear();
    eval(10, 20, mk(1, 500, 500), mk(1, 505, 495), 5);
    push_exp(32'h0010_0400, 1);
    end_frame(1'b0, 32'h0010_0400);

    // Late edge one cycle before done falls; clear while holding.
    do_clear();
    eval(1, 31, mk(1, 0, 0), mk(1, 19, 0), 1);
    bus.mobile_idx     = 5'd11;
    bus.comparison_idx = 5'd12;
    bus.m_sprite       = mk(1, 700, 700);
    bus.c_sprite       = mk(1, 710, 690);
    bus.update_en      = 1'b1;
    tick();
    bus.update_en      = 1'b0;
    push_exp(32'h8000_1802, 2);
    end_frame(1'b1, 32'h8000_1802);

    // Reset in the middle of accumulation discards everything.
    do_clear();
    eval(0, 1, mk(1, 10, 10), mk(1, 12, 12), 1);
    eval(2, 3, mk(1, 10, 10), mk(1, 12, 12), 1);
    eval(4, 6, mk(1, 10, 10), mk(1, 12, 12), 1);
    reset = 1'b0;
    #1;
    check("midrst_flags", bus.collision_flags, 0);
    check("midrst_count", bus.collision_count, 0);
    check("midrst_valid", bus.flags_valid, 0);
    check("midrst_state", bus.state_dbg, IDLE);
    tick();
    reset = 1'b1;
    tick();
    do_clear();
    eval(0, 9, mk(1, 40, 40), mk(1, 45, 45), 1);
    push_exp(32'h0000_0201, 1);
    end_frame(1'b0, 32'h0000_0201);

    // Count saturates at 63 with 70 colliding pairs.
    do_clear();
    for (int i = 0; i < 70; i++)
      eval(i % 32, (i + 1) % 32, mk(1, 10, 10), mk(1, 10, 10), 1);
    push_exp(32'hFFFF_FFFF, 63);
    end_frame(1'b0, 32'hFFFF_FFFF);

    repeat (3) tick();
    check("scoreboard_drained", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
